uart_fifo_core: RTL and testbench

Next-generation UART engine: full-duplex TX and RX in one clock domain, with runtime-programmable baud rate, 16x-oversampled receiver with majority voting, and parametrised TX/RX FIFOs.
It replaces the fixed-rate top plus separate baud-clock module for host-facing links that need buffering and error reporting (parity, framing, overrun).
It sits between a streaming valid/ready source or sink and the board UART pins.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_fifo_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings, timing constants and state enums for the UART engine.
package uart_pkg;

    localparam int CHK_NONE = 0;
    localparam int CHK_EVEN = 1;
    localparam int CHK_ODD  = 2;
    localparam int CHK_ZERO = 3;
    localparam int CHK_ONE  = 4;

    localparam int STOP_ONE      = 0;
    localparam int STOP_ONE_HALF = 1;
    localparam int STOP_TWO      = 2;

    localparam int STOP_TICKS_ONE      = 16;
    localparam int STOP_TICKS_ONE_HALF = 24;
    localparam int STOP_TICKS_TWO      = 32;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_EARLY = 7;
    localparam int SAMPLE_MID   = 8;
    localparam int SAMPLE_LATE  = 9;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    function automatic int stop_ticks(input int mode);
        case (mode)
            STOP_ONE_HALF: return STOP_TICKS_ONE_HALF;
            STOP_TWO:      return STOP_TICKS_TWO;
            default:       return STOP_TICKS_ONE;
        endcase
    endfunction

    function automatic logic parity_bit(input int mode, input logic data_xor);
        case (mode)
            CHK_EVEN: return data_xor;
            CHK_ODD:  return ~data_xor;
            CHK_ONE:  return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO; head is visible on rd_data while not empty.
module uart_sync_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [width-1:0]               wr_data,
    input  logic                           pop,
    output logic [width-1:0]               rd_data,
    output logic [$clog2(depth+1)-1:0]     level,
    output logic                           full,
    output logic                           empty
);
    localparam int AW = $clog2(depth);
    localparam int LW = $clog2(depth+1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;

    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign full    = (count == LW'(depth));
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with programmable baud, 16x oversampled RX and FWFT FIFOs.
module uart_fifo_core #(
    parameter int data_bits  = 8,
    parameter int check_mode = 1,
    parameter int stop_mode  = 0,
    parameter int fifo_depth = 16,
    parameter int div_width  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [div_width-1:0]               baud_div,
    input  logic [data_bits-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx,
    output logic                               tx_busy,
    input  logic                               rx,
    output logic [data_bits-1:0]               rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic                               rx_parity_err,
    output logic                               rx_frame_err,
    output logic                               rx_overrun,
    output logic [$clog2(fifo_depth+1)-1:0]    tx_level,
    output logic [$clog2(fifo_depth+1)-1:0]    rx_level
);
    import uart_pkg::*;

    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(stop_ticks(stop_mode) - 1);
    localparam logic [2:0] DATA_LAST = 3'(data_bits - 1);

    // Divider is reloaded only on wrap so a new baud_div never truncates a tick.
    logic [div_width-1:0] div_q;
    logic [div_width-1:0] tick_cnt;
    logic                 tick16;

    assign tick16 = (tick_cnt == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            div_q    <= div_width'(1);
        end else if (tick16) begin
            tick_cnt <= '0;
            div_q    <= (baud_div == '0) ? div_width'(1) : baud_div;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    logic [data_bits-1:0] tx_head;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_push;
    logic                 tx_pop;

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    uart_sync_fifo #(.width(data_bits), .depth(fifo_depth)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push),
        .wr_data (tx_data),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .level   (tx_level),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    tx_state_t            tx_state;
    logic [4:0]           tx_ticks;
    logic [2:0]           tx_idx;
    logic [data_bits-1:0] tx_shreg;
    logic                 tx_par;
    logic                 tx_bit_end;
    logic                 tx_stop_end;

    assign tx_bit_end  = tick16 && (tx_ticks == BIT_LAST);
    assign tx_stop_end = tick16 && (tx_ticks == STOP_LAST);
    assign tx_pop      = !tx_empty &&
                         ((tx_state == TX_IDLE && tick16) ||
                          (tx_state == TX_STOP && tx_stop_end));
    assign tx_busy     = (tx_state != TX_IDLE) || !tx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_ticks <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
        end else begin
            if (tick16) tx_ticks <= tx_ticks + 1'b1;
            if (tx_pop) begin
                tx_state <= TX_START;
                tx       <= 1'b0;
                tx_shreg <= tx_head;
                tx_par   <= parity_bit(check_mode, ^tx_head);
                tx_ticks <= '0;
                tx_idx   <= '0;
            end else begin
                unique case (tx_state)
                    TX_IDLE: tx <= 1'b1;
                    TX_START: if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx       <= tx_shreg[0];
                        tx_ticks <= '0;
                    end
                    TX_DATA: if (tx_bit_end) begin
                        tx_ticks <= '0;
                        if (tx_idx != DATA_LAST) begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_shreg <= tx_shreg >> 1;
                            tx       <= tx_shreg[1];
                        end else if (check_mode == CHK_NONE) begin
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_state <= TX_PARITY;
                            tx       <= tx_par;
                        end
                    end
                    TX_PARITY: if (tx_bit_end) begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                        tx_ticks <= '0;
                    end
                    TX_STOP: if (tx_stop_end) begin
                        tx_state <= TX_IDLE;
                        tx       <= 1'b1;
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_push;
    logic                 rx_pop;
    logic [data_bits-1:0] rx_shreg;

    uart_sync_fifo #(.width(data_bits), .depth(fifo_depth)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .wr_data (rx_shreg),
        .pop     (rx_pop),
        .rd_data (rx_data),
        .level   (rx_level),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    rx_state_t  rx_state;
    logic       rx_s1;
    logic       rx_s2;
    logic       rx_prev;
    logic [3:0] rx_ticks;
    logic [2:0] rx_idx;
    logic       s_early;
    logic       s_mid;
    logic       rx_par;
    logic       rx_maj;
    logic       rx_decide;
    logic       rx_bit_end;
    logic       stop_eval;

    assign rx_maj     = (s_early & s_mid) | (s_early & rx_s2) | (s_mid & rx_s2);
    assign rx_decide  = tick16 && (rx_ticks == 4'(SAMPLE_LATE));
    assign rx_bit_end = tick16 && (rx_ticks == 4'(OVERSAMPLE - 1));
    assign stop_eval  = (rx_state == RX_STOP) && rx_decide;
    assign rx_valid   = !rx_empty;
    assign rx_pop     = !rx_empty && rx_ready;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign rx_push    = stop_eval && (!rx_full || rx_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_ticks      <= '0;
            rx_idx        <= '0;
            s_early       <= 1'b1;
            s_mid         <= 1'b1;
            rx_shreg      <= '0;
            rx_par        <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_s1         <= rx;
            rx_s2         <= rx_s1;
            rx_prev       <= rx_s2;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            if (tick16) rx_ticks <= rx_ticks + 1'b1;
            if (tick16 && rx_ticks == 4'(SAMPLE_EARLY)) s_early <= rx_s2;
            if (tick16 && rx_ticks == 4'(SAMPLE_MID))   s_mid   <= rx_s2;
            unique case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_ticks <= '0;
                    rx_idx   <= '0;
                end
                RX_START: begin
                    if (rx_decide && rx_maj) rx_state <= RX_IDLE;
                    else if (rx_bit_end)     rx_state <= RX_DATA;
                end
                RX_DATA: begin
                    if (rx_decide) rx_shreg <= {rx_maj, rx_shreg[data_bits-1:1]};
                    if (rx_bit_end) begin
                        if (rx_idx != DATA_LAST) begin
                            rx_idx <= rx_idx + 1'b1;
                        end else begin
                            rx_idx   <= '0;
                            rx_state <= (check_mode == CHK_NONE) ? RX_STOP : RX_PARITY;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_decide)  rx_par   <= rx_maj;
                    if (rx_bit_end) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_decide) begin
                    rx_state      <= RX_IDLE;
                    rx_parity_err <= (check_mode != CHK_NONE) &&
                                     (rx_par != parity_bit(check_mode, ^rx_shreg));
                    rx_frame_err  <= !rx_maj;
                    rx_overrun    <= rx_full && !rx_pop;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: loopback, burst, glitch, errors, overrun, reset.
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx;
    logic        tx_busy;
    logic        rx;
    logic        rx_man = 1'b1;
    logic        loopback = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_parity_err;
    logic        rx_frame_err;
    logic        rx_overrun;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovr = 0;

    assign rx = loopback ? tx : rx_man;

    uart_fifo_core #(
        .data_bits(8), .check_mode(1), .stop_mode(0),
        .fifo_depth(16), .div_width(16)
    ) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx(tx), .tx_busy(tx_busy), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun), .tx_level(tx_level), .rx_level(rx_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_parity_err) n_par <= n_par + 1;
        if (rx_frame_err)  n_frm <= n_frm + 1;
        if (rx_overrun)    n_ovr <= n_ovr + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_low(output int ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (tx == 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Start, 8 data LSB first, even parity, stop; sampled at mid-bit.
    task automatic check_tx_frame(input logic [7:0] d, input string tag);
        logic [10:0] f;
        int ok;
        f = {1'b1, ^d, d, 1'b0};
        wait_tx_low(ok);
        chk({tag, "_start_seen"}, ok, 1);
        tick(16);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), tx, f[i]);
            if (i < 10) tick(32);
        end
    endtask

    task automatic pop_rx(input logic [7:0] exp, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 1500; i++) begin
            if (rx_valid) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        chk({tag, "_valid"}, ok, 1);
        chk({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_b);
        logic [10:0] f;
        f = {stop_b, (^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_man = f[i];
            tick(32);
        end
        rx_man = 1'b1;
        tick(32);
    endtask

    initial begin
        int p0, f0, o0, ok, c0, c1;

        tick(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_errs", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);

        loopback = 1'b1;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        push_tx(8'hA5);
        chk("a5_busy", tx_busy, 1'b1);
        check_tx_frame(8'hA5, "a5");
        pop_rx(8'hA5, "a5_rx");
        chk("a5_no_err", (n_par - p0) + (n_frm - f0) + (n_ovr - o0), 0);

        tick(40);
        push_tx(8'hFF);
        wait_tx_low(ok);
        chk("burst_lead_start", ok, 1);
        c0 = cyc;
        for (int k = 0; k < 16; k++) push_tx(8'(k));
        chk("burst_level", tx_level, 16);
        chk("burst_ready", tx_ready, 1'b0);
        pop_rx(8'hFF, "burst_rx_lead");
        for (int k = 0; k < 16; k++) pop_rx(8'(k), $sformatf("burst_rx%0d", k));
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!tx_busy) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        c1 = cyc;
        chk("burst_idle_seen", ok, 1);
        chk("burst_no_gap_cycles", c1 - c0, 17 * 352);

        loopback = 1'b0;
        tick(40);
        rx_man = 1'b0;
        tick(4);
        rx_man = 1'b1;
        tick(100);
        chk("glitch_rx_valid", rx_valid, 1'b0);
        chk("glitch_rx_level", rx_level, 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        pop_rx(8'h3C, "glitch_after");

        p0 = n_par; f0 = n_frm;
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("par_err_pulses", n_par - p0, 1);
        chk("par_no_frame_err", n_frm - f0, 0);
        pop_rx(8'h5A, "par_err_byte");

        p0 = n_par; f0 = n_frm;
        send_frame(8'h81, 1'b0, 1'b0);
        chk("frm_err_pulses", n_frm - f0, 1);
        chk("frm_no_par_err", n_par - p0, 0);
        pop_rx(8'h81, "frm_err_byte");

        o0 = n_ovr;
        for (int k = 0; k < 17; k++) send_frame(8'(8'h20 + k), 1'b0, 1'b1);
        chk("ovr_level", rx_level, 16);
        chk("ovr_pulses", n_ovr - o0, 1);
        chk("ovr_head", rx_data, 8'h20);
        rx_ready = 1'b1;
        tick(16);
        rx_ready = 1'b0;
        chk("ovr_drained", rx_level, 0);

        loopback = 1'b1;
        tick(10);
        push_tx(8'hF0);
        push_tx(8'h77);
        wait_tx_low(ok);
        chk("rstmid_start", ok, 1);
        tick(144);
        chk("rstmid_d3_low", tx, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_tx_level", tx_level, 0);
        chk("rstmid_tx_busy", tx_busy, 1'b0);
        chk("rstmid_rx_level", rx_level, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        push_tx(8'h55);
        check_tx_frame(8'h55, "post_rst");
        pop_rx(8'h55, "post_rst_rx");
        tick(20);
        chk("post_rst_empty", rx_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
